// File: rtl/btn_pkg.sv
// btn_pkg: debounce FSM state type and counter-width helper shared by the button bank.
package btn_pkg;
    typedef enum logic [1:0] {IDLE, WAIT1, ONE, WAIT0} db_state_t;
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-FF synchroniser plus debounce/long-press FSM for one button.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS = 3,
    parameter int LONG_TICKS   = 100,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic tick,
    output logic db,
    output logic press,
    output logic release_p,
    output logic long_press
);
    localparam int CW = cnt_w(STABLE_TICKS);
    localparam int HW = cnt_w(LONG_TICKS);
    localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_TICKS);
    logic [1:0] sync;
    logic s, fired, fired_n, press_n, rel_n, long_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [HW-1:0] hcnt, hcnt_n;
    db_state_t state, state_n;
    assign s  = sync[1] ^ ACTIVE_LOW;
    assign db = (state == ONE) || (state == WAIT0);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync       <= {2{ACTIVE_LOW}};
            state      <= IDLE;
            cnt        <= '0;
            hcnt       <= '0;
            fired      <= 1'b0;
            press      <= 1'b0;
            release_p  <= 1'b0;
            long_press <= 1'b0;
        end else begin
            sync       <= {sync[0], btn};
            state      <= state_n;
            cnt        <= cnt_n;
            hcnt       <= hcnt_n;
            fired      <= fired_n;
            press      <= press_n;
            release_p  <= rel_n;
            long_press <= long_n;
        end
    end
    // A level change on s always takes priority over a tick in the same cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hcnt_n  = hcnt;
        fired_n = fired;
        press_n = 1'b0;
        rel_n   = 1'b0;
        long_n  = 1'b0;
        case (state)
            IDLE: if (s) begin
                state_n = WAIT1;
                cnt_n   = '0;
            end
            WAIT1: if (!s) state_n = IDLE;
            else if (tick) begin
                if (cnt == C_LAST) begin
                    state_n = ONE;
                    press_n = 1'b1;
                    hcnt_n  = '0;
                end else cnt_n = cnt + 1'b1;
            end
            ONE: if (!s) begin
                state_n = WAIT0;
                cnt_n   = '0;
            end else if (tick) begin
                hcnt_n = (hcnt == H_MAX) ? hcnt : hcnt + 1'b1;
                if (LONG_TICKS != 0 && hcnt == H_LAST && !fired) begin
                    long_n  = 1'b1;
                    fired_n = 1'b1;
                end
            end
            default: if (s) state_n = ONE;
            else if (tick) begin
                if (cnt == C_LAST) begin
                    state_n = IDLE;
                    rel_n   = 1'b1;
                    fired_n = 1'b0;
                end else cnt_n = cnt + 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/button_debounce_bank.sv
// button_debounce_bank: N independent button conditioners sharing one tick prescaler.
module button_debounce_bank
    import btn_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 500000,
    parameter int STABLE_TICKS = 3,
    parameter int LONG_TICKS   = 100,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] db,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_p,
    output logic [N_BTN-1:0] long_press,
    output logic             tick
);
    localparam int QW = $clog2(TICK_DIV);
    localparam logic [QW-1:0] Q_LAST = QW'(TICK_DIV - 1);
    logic [QW-1:0] q;
    assign tick = (q == Q_LAST);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else q <= tick ? '0 : q + 1'b1;
    end
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS),
            .LONG_TICKS  (LONG_TICKS),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .btn       (btn[i]),
            .tick      (tick),
            .db        (db[i]),
            .press     (press[i]),
            .release_p (release_p[i]),
            .long_press(long_press[i])
        );
    end
endmodule

// File: tb/tb_button_debounce_bank.sv
// tb_button_debounce_bank: level-based reference model plus directed timing checks for both polarities.
module tb_button_debounce_bank;
    localparam int N = 2, TD = 4, ST = 3, LT = 5;
    logic clk = 1'b0, reset = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] db, press, release_p, long_press;
    logic [N-1:0] db_a, press_a, release_a, long_a;
    logic tick, tick_a;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    button_debounce_bank #(.N_BTN(N), .TICK_DIV(TD), .STABLE_TICKS(ST), .LONG_TICKS(LT), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset), .btn(btn), .db(db), .press(press),
        .release_p(release_p), .long_press(long_press), .tick(tick)
    );
    button_debounce_bank #(.N_BTN(N), .TICK_DIV(TD), .STABLE_TICKS(ST), .LONG_TICKS(LT), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .reset(reset), .btn(~btn), .db(db_a), .press(press_a),
        .release_p(release_a), .long_press(long_a), .tick(tick_a)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the level follows the pressed state once it has stayed different
    // for ST whole ticks; ticks in the cycle the difference first appears do not count.
    int mq;
    int run [N];
    int hold [N];
    logic [N-1:0] sh1, sh2, m_db, m_press, m_rel, m_long, off_prev, fired;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq = 0; sh1 = '0; sh2 = '0; m_db = '0; m_press = '0; m_rel = '0;
            m_long = '0; off_prev = '0; fired = '0;
            for (int c = 0; c < N; c++) begin run[c] = 0; hold[c] = 0; end
        end else begin
            automatic bit t = (mq == TD - 1);
            mq = t ? 0 : mq + 1;
            for (int c = 0; c < N; c++) begin
                automatic bit s = sh2[c];
                automatic bit off = (s != m_db[c]);
                m_press[c] = 0; m_rel[c] = 0; m_long[c] = 0;
                if (!off) begin
                    run[c] = 0;
                    if (s && !off_prev[c] && t) begin
                        hold[c]++;
                        if (hold[c] == LT && !fired[c]) begin m_long[c] = 1; fired[c] = 1; end
                    end
                end else if (off_prev[c] && t) begin
                    run[c]++;
                    if (run[c] == ST) begin
                        m_db[c] = s; run[c] = 0; off = 0;
                        m_press[c] = s; m_rel[c] = !s;
                        if (s) hold[c] = 0; else fired[c] = 0;
                    end
                end
                off_prev[c] = off;
            end
            sh2 = sh1;
            sh1 = btn;
        end
    end

    always @(negedge clk) begin
        check("db", int'(db), int'(m_db));
        check("press", int'(press), int'(m_press));
        check("release_p", int'(release_p), int'(m_rel));
        check("long_press", int'(long_press), int'(m_long));
        check("tick", int'(tick), int'(mq == TD - 1));
        check("al_db", int'(db_a), int'(m_db));
        check("al_press", int'(press_a), int'(m_press));
        check("al_release_p", int'(release_a), int'(m_rel));
        check("al_long_press", int'(long_a), int'(m_long));
        check("al_tick", int'(tick_a), int'(mq == TD - 1));
    end

    task automatic wait_tick(output int n);
        n = 0;
        while (n == 0 || (!tick && n < 50)) begin @(negedge clk); n++; end
    endtask

    function automatic int pulses();
        return $countones({press, release_p, long_press, db});
    endfunction

    initial begin
        int n, k;
        int hold_left [N];
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", pulses() + int'(tick), 0);
        reset = 1'b0;
        wait_tick(n); check("tick_first", n, 3);
        wait_tick(n); check("tick_period", n, 4);
        // clean press, aligned to a tick cycle
        btn[0] = 1'b1; n = 0;
        while (!db[0] && n < 100) begin @(negedge clk); n++; end
        check("press_latency", n, 13);
        check("press_pulse", int'(press[0]), 1);
        check("ch1_quiet", int'(db[1] | press[1]), 0);
        @(negedge clk); n = 1;
        check("press_one_cycle", int'(press[0]), 0);
        while (!long_press[0] && n < 100) begin @(negedge clk); n++; end
        check("long_latency", n, 20);
        k = 0;
        repeat (80) begin @(negedge clk); k += int'(long_press[0]); end
        check("long_once", k, 0);
        // short release glitch
        btn[0] = 1'b0; repeat (5) @(negedge clk); btn[0] = 1'b1; k = 0;
        repeat (30) begin @(negedge clk); k += int'(release_p[0]) + int'(press[0]); end
        check("glitch_pulses", k, 0);
        check("glitch_db", int'(db[0]), 1);
        wait_tick(n); btn[0] = 1'b0; n = 0;
        while (!release_p[0] && n < 100) begin @(negedge clk); n++; end
        check("release_latency", n, 13);
        check("release_db", int'(db[0]), 0);
        // bounce
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn[0] = ~btn[0];
            @(negedge clk); k += int'(press[0]) + int'(db[0]);
        end
        btn[0] = 1'b0;
        repeat (10) begin @(negedge clk); k += int'(press[0]) + int'(db[0]); end
        check("bounce_quiet", k, 0);
        // reset mid-WAIT1
        btn[0] = 1'b1; repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("rst_wait1_async", pulses() + int'(tick), 0);
        btn[0] = 1'b0; @(negedge clk); #2 reset = 1'b0; k = 0;
        repeat (40) begin @(negedge clk); k += pulses(); end
        check("rst_wait1_quiet", k, 0);
        // reset mid-hold
        btn[0] = 1'b1; n = 0;
        while (!db[0] && n < 100) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("rst_hold_async", pulses() + int'(db_a), 0);
        btn[0] = 1'b0; @(negedge clk); #2 reset = 1'b0; k = 0;
        repeat (40) begin @(negedge clk); k += pulses(); end
        check("rst_hold_quiet", k, 0);
        // randomized traffic on both channels
        for (int c = 0; c < N; c++) hold_left[c] = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                if (hold_left[c] == 0) begin
                    btn[c] = ~btn[c];
                    hold_left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 120) : $urandom_range(1, 20);
                end else hold_left[c]--;
            end
            if ($urandom_range(0, 699) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
            end
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
